// File: rtl/lpc_defs_pkg.sv
// lpc_defs_pkg: shared LPC definitions for the host cycle generator and the
// peripheral receiver.
// Contents: START, CYCTYPE/DIR and SYNC nibble codes, completion status
// encodings, host FSM state encoding and a nibble-select helper.
package lpc_defs_pkg;

  localparam logic [3:0] START_IO     = 4'b0000;
  localparam logic [3:0] START_TPM    = 4'b0101;

  localparam logic [3:0] CYCDIR_IO_RD = 4'b0000;
  localparam logic [3:0] CYCDIR_IO_WR = 4'b0010;

  localparam logic [3:0] SYNC_READY   = 4'b0000;
  localparam logic [3:0] SYNC_SHORT   = 4'b0101;
  localparam logic [3:0] SYNC_LONG    = 4'b0110;
  localparam logic [3:0] SYNC_ERROR   = 4'b1010;

  localparam logic [3:0] LAD_IDLE     = 4'b1111;

  typedef enum logic [1:0] {
    RSP_OK       = 2'b00,
    RSP_SYNC_ERR = 2'b01,
    RSP_NORESP   = 2'b10,
    RSP_TIMEOUT  = 2'b11
  } rsp_status_e;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_CYCDIR = 4'd2,
    ST_ADDR   = 4'd3,
    ST_WDATA  = 4'd4,
    ST_TARH   = 4'd5,
    ST_SYNC   = 4'd6,
    ST_RDATA  = 4'd7,
    ST_TART   = 4'd8,
    ST_ABORT  = 4'd9
  } lpc_state_e;

  // idx 3 selects addr[15:12] ... idx 0 selects addr[3:0]
  function automatic logic [3:0] addr_nibble(input logic [15:0] addr, input logic [1:0] idx);
    return addr[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/lpc_sync_timer.sv
// lpc_sync_timer: SYNC-phase supervision for the LPC host.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   clear          zero all counters (asserted on the clock before SYNC)
//   sample         high in every SYNC clock; lad is evaluated then
//   lad            sampled LAD value
//   ready          SYNC 0000 or 1010 seen this clock
//   err            SYNC 1010 seen this clock
//   abort          a wait or no-response limit was hit this clock
//   abort_code     RSP_TIMEOUT (wait limit) or RSP_NORESP
module lpc_sync_timer
  import lpc_defs_pkg::*;
#(
  parameter int SHORT_WAIT_MAX = 8,
  parameter int LONG_WAIT_MAX  = 1024,
  parameter int NORESP_MAX     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        sample,
  input  logic [3:0]  lad,
  output logic        ready,
  output logic        err,
  output logic        abort,
  output rsp_status_e abort_code
);

  // Sized so LONG_WAIT_MAX+1 fits without wrapping.
  localparam int CW = $clog2(LONG_WAIT_MAX + 2);
  localparam logic [CW-1:0] SHORT_LIM  = CW'(SHORT_WAIT_MAX);
  localparam logic [CW-1:0] LONG_LIM   = CW'(LONG_WAIT_MAX);
  localparam logic [CW-1:0] NORESP_LIM = CW'(NORESP_MAX);

  logic [CW-1:0] short_cnt, long_cnt, noresp_cnt;
  logic [CW-1:0] short_nxt, long_nxt, noresp_nxt;
  logic          wait_to, noresp_to;

  always_comb begin
    short_nxt  = short_cnt;
    long_nxt   = long_cnt;
    noresp_nxt = noresp_cnt;
    case (lad)
      SYNC_READY, SYNC_ERROR: begin
        short_nxt  = '0;
        long_nxt   = '0;
        noresp_nxt = '0;
      end
      SYNC_SHORT: begin
        short_nxt  = short_cnt + CW'(1);
        long_nxt   = '0;
        noresp_nxt = '0;
      end
      SYNC_LONG: begin
        long_nxt   = long_cnt + CW'(1);
        short_nxt  = '0;
        noresp_nxt = '0;
      end
      // Garbage on the bus does not disturb the wait counters.
      default: noresp_nxt = noresp_cnt + CW'(1);
    endcase
  end

  assign wait_to    = (short_nxt > SHORT_LIM) || (long_nxt > LONG_LIM);
  assign noresp_to  = (noresp_nxt == NORESP_LIM);
  assign ready      = sample && ((lad == SYNC_READY) || (lad == SYNC_ERROR));
  assign err        = sample && (lad == SYNC_ERROR);
  assign abort      = sample && (wait_to || noresp_to);
  assign abort_code = wait_to ? RSP_TIMEOUT : RSP_NORESP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      short_cnt  <= '0;
      long_cnt   <= '0;
      noresp_cnt <= '0;
    end else if (clear) begin
      short_cnt  <= '0;
      long_cnt   <= '0;
      noresp_cnt <= '0;
    end else if (sample) begin
      short_cnt  <= short_nxt;
      long_cnt   <= long_nxt;
      noresp_cnt <= noresp_nxt;
    end
  end

endmodule

// File: rtl/lpc_host_cycle_gen.sv
// lpc_host_cycle_gen: LPC host cycle generator. Turns one I/O or TPM
// read/write command into a full LFRAME#/LAD frame and returns read data and
// a completion status.
// Ports:
//   lpc_lclk, lpc_lreset_n      LPC clock, async active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_wr, cmd_tpm, cmd_addr,  command fields, captured on accept
//   cmd_wdata
//   rsp_valid, rsp_rdata,       one-clock completion pulse with data/status
//   rsp_status
//   lpc_lframe_n, lpc_lad_o,    bus drive side (inout built one level up)
//   lpc_lad_oe, lpc_lad_i
//
// state  | meaning
// IDLE   | no frame; cmd_ready=1
// START  | LFRAME# low, START code driven
// CYCDIR | cycle type / direction nibble
// ADDR   | 4 address nibbles, MSN first
// WDATA  | write data, low nibble first (writes only)
// TARH   | host turnaround: drive 1111, then release
// SYNC   | target SYNC sampled until ready/error/abort
// RDATA  | read data sampled, low nibble first (reads only)
// TART   | target turnaround, bus released
// ABORT  | 4 clocks LFRAME# low with 1111, then 1 clock released
//
// Outputs are registered from a decode of the next state, so the frame shows
// up on the clock after accept and rsp_valid coincides with the return to IDLE.
module lpc_host_cycle_gen
  import lpc_defs_pkg::*;
#(
  parameter int SHORT_WAIT_MAX = 8,
  parameter int LONG_WAIT_MAX  = 1024,
  parameter int NORESP_MAX     = 3
) (
  input  logic        lpc_lclk,
  input  logic        lpc_lreset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic        cmd_tpm,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [1:0]  rsp_status,
  output logic        lpc_lframe_n,
  output logic [3:0]  lpc_lad_o,
  output logic        lpc_lad_oe,
  input  logic [3:0]  lpc_lad_i
);

  lpc_state_e  state, state_nxt;
  logic [2:0]  phase, phase_nxt;      // down-counter within multi-clock states
  logic        accept;

  logic        cap_wr;
  logic [15:0] cap_addr;
  logic [7:0]  cap_wdata;
  logic [7:0]  rdata;
  rsp_status_e status;

  logic        sync_clear, sync_sample;
  logic        sync_ready, sync_err, sync_abort;
  rsp_status_e sync_abort_code;

  logic        lframe_d, oe_d, ready_d, rsp_valid_d;
  logic [3:0]  lad_d;
  logic [7:0]  rsp_rdata_d;
  logic [1:0]  rsp_status_d;

  assign accept      = cmd_valid && cmd_ready;
  assign sync_clear  = (state == ST_TARH) && (phase == 3'd0);
  assign sync_sample = (state == ST_SYNC);

  lpc_sync_timer #(
    .SHORT_WAIT_MAX (SHORT_WAIT_MAX),
    .LONG_WAIT_MAX  (LONG_WAIT_MAX),
    .NORESP_MAX     (NORESP_MAX)
  ) u_sync_timer (
    .clk        (lpc_lclk),
    .rst_n      (lpc_lreset_n),
    .clear      (sync_clear),
    .sample     (sync_sample),
    .lad        (lpc_lad_i),
    .ready      (sync_ready),
    .err        (sync_err),
    .abort      (sync_abort),
    .abort_code (sync_abort_code)
  );

  // State register
  always_ff @(posedge lpc_lclk or negedge lpc_lreset_n) begin
    if (!lpc_lreset_n) begin
      state <= ST_IDLE;
      phase <= 3'd0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  // Next state; phase is loaded with (length-1) on entry
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_START;
          phase_nxt = 3'd0;
        end
      end
      ST_START: begin
        state_nxt = ST_CYCDIR;
        phase_nxt = 3'd0;
      end
      ST_CYCDIR: begin
        state_nxt = ST_ADDR;
        phase_nxt = 3'd3;
      end
      ST_ADDR: begin
        if (phase == 3'd0) begin
          state_nxt = cap_wr ? ST_WDATA : ST_TARH;
          phase_nxt = 3'd1;
        end else begin
          phase_nxt = phase - 3'd1;
        end
      end
      ST_WDATA: begin
        if (phase == 3'd0) begin
          state_nxt = ST_TARH;
          phase_nxt = 3'd1;
        end else begin
          phase_nxt = phase - 3'd1;
        end
      end
      ST_TARH: begin
        if (phase == 3'd0) begin
          state_nxt = ST_SYNC;
          phase_nxt = 3'd0;
        end else begin
          phase_nxt = phase - 3'd1;
        end
      end
      ST_SYNC: begin
        if (sync_abort) begin
          state_nxt = ST_ABORT;
          phase_nxt = 3'd4;
        end else if (sync_ready) begin
          state_nxt = cap_wr ? ST_TART : ST_RDATA;
          phase_nxt = 3'd1;
        end
      end
      ST_RDATA: begin
        if (phase == 3'd0) begin
          state_nxt = ST_TART;
          phase_nxt = 3'd1;
        end else begin
          phase_nxt = phase - 3'd1;
        end
      end
      ST_TART, ST_ABORT: begin
        if (phase == 3'd0) begin
          state_nxt = ST_IDLE;
          phase_nxt = 3'd0;
        end else begin
          phase_nxt = phase - 3'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        phase_nxt = 3'd0;
      end
    endcase
  end

  // Command capture, read data and status tracking
  always_ff @(posedge lpc_lclk or negedge lpc_lreset_n) begin
    if (!lpc_lreset_n) begin
      cap_wr    <= 1'b0;
      cap_addr  <= 16'h0000;
      cap_wdata <= 8'h00;
      rdata     <= 8'h00;
      status    <= RSP_OK;
    end else begin
      if (accept) begin
        cap_wr    <= cmd_wr;
        cap_addr  <= cmd_addr;
        cap_wdata <= cmd_wdata;
        status    <= RSP_OK;
      end
      if (sync_abort) begin
        status <= sync_abort_code;
      end else if (sync_ready) begin
        status <= sync_err ? RSP_SYNC_ERR : RSP_OK;
      end
      if (state == ST_RDATA) begin
        if (phase == 3'd1) rdata[3:0] <= lpc_lad_i;
        else               rdata[7:4] <= lpc_lad_i;
      end
    end
  end

  // Output decode of the upcoming state
  always_comb begin
    lframe_d     = 1'b1;
    oe_d         = 1'b0;
    lad_d        = LAD_IDLE;
    ready_d      = (state_nxt == ST_IDLE);
    rsp_valid_d  = (state != ST_IDLE) && (state_nxt == ST_IDLE);
    rsp_rdata_d  = rsp_rdata;
    rsp_status_d = rsp_status;

    if (rsp_valid_d) begin
      rsp_status_d = status;
      if (cap_wr)
        rsp_rdata_d = 8'h00;
      else if ((status == RSP_NORESP) || (status == RSP_TIMEOUT))
        rsp_rdata_d = 8'hFF;
      else
        rsp_rdata_d = rdata;
    end

    case (state_nxt)
      ST_START: begin
        // START is only entered on accept, before cap_* are loaded
        lframe_d = 1'b0;
        oe_d     = 1'b1;
        lad_d    = cmd_tpm ? START_TPM : START_IO;
      end
      ST_CYCDIR: begin
        oe_d  = 1'b1;
        lad_d = cap_wr ? CYCDIR_IO_WR : CYCDIR_IO_RD;
      end
      ST_ADDR: begin
        oe_d  = 1'b1;
        lad_d = addr_nibble(cap_addr, phase_nxt[1:0]);
      end
      ST_WDATA: begin
        oe_d  = 1'b1;
        lad_d = (phase_nxt == 3'd1) ? cap_wdata[3:0] : cap_wdata[7:4];
      end
      ST_TARH: begin
        // Second TARH clock is always released: guaranteed turnaround
        oe_d = (phase_nxt == 3'd1);
      end
      ST_ABORT: begin
        if (phase_nxt != 3'd0) begin
          lframe_d = 1'b0;
          oe_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge lpc_lclk or negedge lpc_lreset_n) begin
    if (!lpc_lreset_n) begin
      lpc_lframe_n <= 1'b1;
      lpc_lad_oe   <= 1'b0;
      lpc_lad_o    <= LAD_IDLE;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'h00;
      rsp_status   <= RSP_OK;
    end else begin
      lpc_lframe_n <= lframe_d;
      lpc_lad_oe   <= oe_d;
      lpc_lad_o    <= lad_d;
      cmd_ready    <= ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rsp_rdata_d;
      rsp_status   <= rsp_status_d;
    end
  end

endmodule

// File: tb/tb_lpc_host_cycle_gen.sv
module tb_lpc_host_cycle_gen;

  logic        lpc_lclk = 1'b0;
  logic        lpc_lreset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic        cmd_tpm = 1'b0;
  logic [15:0] cmd_addr = 16'h0000;
  logic [7:0]  cmd_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [1:0]  rsp_status;
  logic        lpc_lframe_n;
  logic [3:0]  lpc_lad_o;
  logic        lpc_lad_oe;
  logic [3:0]  lpc_lad_i = 4'hF;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       lf;
    logic       oe;
    logic [3:0] lad;
  } beat_t;

  beat_t      exp_q[$];   // expected bus state per frame clock
  logic [3:0] tgt_q[$];   // what the target drives per frame clock
  logic [3:0] sync_q[$];  // target SYNC script; F is driven once it runs out
  logic [3:0] code_pool [6] = '{4'h0, 4'hA, 4'h5, 4'h6, 4'hF, 4'h3};

  always #15 lpc_lclk = ~lpc_lclk;

  lpc_host_cycle_gen dut (
    .lpc_lclk     (lpc_lclk),
    .lpc_lreset_n (lpc_lreset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wr       (cmd_wr),
    .cmd_tpm      (cmd_tpm),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_status   (rsp_status),
    .lpc_lframe_n (lpc_lframe_n),
    .lpc_lad_o    (lpc_lad_o),
    .lpc_lad_oe   (lpc_lad_oe),
    .lpc_lad_i    (lpc_lad_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic lf, input logic oe, input logic [3:0] lad, input logic [3:0] tgt);
    beat_t b;
    b.lf = lf; b.oe = oe; b.lad = lad;
    exp_q.push_back(b);
    tgt_q.push_back(tgt);
  endtask

  // Reference model: frame layout, SYNC outcome and response from the protocol rules.
  task automatic build_frame(input logic wr, input logic tpm, input logic [15:0] addr,
                             input logic [7:0] wdata, input logic [7:0] rd,
                             output logic [1:0] st, output logic [7:0] rd_exp);
    int s, l, n, k;
    bit done, aborted;
    logic [3:0] code;
    exp_q.delete();
    tgt_q.delete();
    add(1'b0, 1'b1, tpm ? 4'h5 : 4'h0, 4'hF);
    add(1'b1, 1'b1, wr ? 4'h2 : 4'h0, 4'hF);
    for (int a = 3; a >= 0; a--) add(1'b1, 1'b1, addr[4*a +: 4], 4'hF);
    if (wr) begin
      add(1'b1, 1'b1, wdata[3:0], 4'hF);
      add(1'b1, 1'b1, wdata[7:4], 4'hF);
    end
    add(1'b1, 1'b1, 4'hF, 4'hF);
    add(1'b1, 1'b0, 4'hF, 4'hF);
    s = 0; l = 0; n = 0; k = 0; done = 0; aborted = 0; st = 2'b00;
    while (!done) begin
      code = (k < sync_q.size()) ? sync_q[k] : 4'hF;
      add(1'b1, 1'b0, 4'hF, code);
      k++;
      case (code)
        4'h0: begin st = 2'b00; done = 1; end
        4'hA: begin st = 2'b01; done = 1; end
        4'h5: begin s++; l = 0; n = 0; end
        4'h6: begin l++; s = 0; n = 0; end
        default: n++;
      endcase
      if (!done) begin
        if (s > 8 || l > 1024) begin st = 2'b11; done = 1; aborted = 1; end
        else if (n == 3)       begin st = 2'b10; done = 1; aborted = 1; end
      end
    end
    if (aborted) begin
      repeat (4) add(1'b0, 1'b1, 4'hF, 4'hF);
      add(1'b1, 1'b0, 4'hF, 4'hF);
      rd_exp = wr ? 8'h00 : 8'hFF;
    end else begin
      if (!wr) begin
        add(1'b1, 1'b0, 4'hF, rd[3:0]);
        add(1'b1, 1'b0, 4'hF, rd[7:4]);
      end
      add(1'b1, 1'b0, 4'hF, 4'hF);
      add(1'b1, 1'b0, 4'hF, 4'hF);
      rd_exp = wr ? 8'h00 : rd;
    end
  endtask

  // Issue one command (called at a negedge) and check every clock of the frame.
  // reset_at >= 0 returns early at that frame clock so the caller can reset.
  task automatic run_cmd(input string name, input logic wr, input logic tpm,
                         input logic [15:0] addr, input logic [7:0] wdata,
                         input logic [7:0] rd, input int reset_at);
    logic [1:0] st;
    logic [7:0] rd_exp;
    int w;
    build_frame(wr, tpm, addr, wdata, rd, st, rd_exp);
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin
      @(negedge lpc_lclk);
      w++;
    end
    chk({name, ".ready"}, 32'(cmd_ready), 32'(1));
    cmd_valid = 1'b1; cmd_wr = wr; cmd_tpm = tpm; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge lpc_lclk);
    #1;
    cmd_valid = 1'b0;
    cmd_wr = 1'($urandom); cmd_tpm = 1'($urandom);
    cmd_addr = 16'($urandom); cmd_wdata = 8'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge lpc_lclk);
      if (i == reset_at) return;
      lpc_lad_i = tgt_q[i];
      chk($sformatf("%s.cyc%0d", name, i),
          32'({lpc_lframe_n, lpc_lad_oe, lpc_lad_oe ? lpc_lad_o : 4'h0, rsp_valid, cmd_ready}),
          32'({exp_q[i].lf, exp_q[i].oe, exp_q[i].oe ? exp_q[i].lad : 4'h0, 1'b0, 1'b0}));
    end
    @(negedge lpc_lclk);
    lpc_lad_i = 4'hF;
    chk({name, ".rsp"}, 32'({rsp_valid, cmd_ready, rsp_status, rsp_rdata}),
        32'({1'b1, 1'b1, st, rd_exp}));
  endtask

  task automatic set_sync(input logic [3:0] code, input int cnt, input bit clear_first);
    if (clear_first) sync_q.delete();
    repeat (cnt) sync_q.push_back(code);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, len;
    logic wr;
    repeat (2) @(negedge lpc_lclk);
    chk("reset", 32'({lpc_lframe_n, lpc_lad_oe, lpc_lad_o, cmd_ready, rsp_valid, rsp_rdata, rsp_status}),
        32'({1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 8'h00, 2'b00}));
    lpc_lreset_n = 1'b1;
    #1 chk("ready_at_release", 32'(cmd_ready), 32'(0));
    @(negedge lpc_lclk);
    chk("ready_after_release", 32'(cmd_ready), 32'(1));

    // I/O write 0x0080 <- 0xA5, immediate ready
    set_sync(4'h0, 1, 1);
    run_cmd("io_wr", 1'b1, 1'b0, 16'h0080, 8'hA5, 8'h00, -1);
    // TPM read with two long waits
    set_sync(4'h6, 2, 1); set_sync(4'h0, 1, 0);
    run_cmd("tpm_rd", 1'b0, 1'b1, 16'h0024, 8'h00, 8'h3C, -1);
    // No response at all
    sync_q.delete();
    run_cmd("noresp", 1'b0, 1'b0, 16'h0060, 8'h00, 8'h77, -1);
    // Short wait limit exceeded, then exactly at the limit
    set_sync(4'h5, 9, 1);
    run_cmd("short_to", 1'b1, 1'b0, 16'h1234, 8'h5E, 8'h00, -1);
    set_sync(4'h5, 8, 1); set_sync(4'h0, 1, 0);
    run_cmd("short_ok", 1'b1, 1'b0, 16'h1234, 8'h5E, 8'h00, -1);
    // SYNC error still transfers data
    set_sync(4'hA, 1, 1);
    run_cmd("sync_err", 1'b0, 1'b0, 16'h02F8, 8'h00, 8'h5A, -1);
    // Long wait limit exceeded, then exactly at the limit
    set_sync(4'h6, 1025, 1);
    run_cmd("long_to", 1'b0, 1'b1, 16'hD400, 8'h00, 8'h11, -1);
    set_sync(4'h6, 1024, 1); set_sync(4'h0, 1, 0);
    run_cmd("long_ok", 1'b0, 1'b1, 16'hD400, 8'h00, 8'h96, -1);
    // A long wait clears the short count; a valid code clears the no-response count
    set_sync(4'h5, 8, 1); set_sync(4'h6, 1, 0); set_sync(4'h5, 8, 0); set_sync(4'h0, 1, 0);
    run_cmd("mix_wait", 1'b1, 1'b1, 16'h00FF, 8'hC3, 8'h00, -1);
    set_sync(4'hF, 2, 1); set_sync(4'h5, 1, 0); set_sync(4'h3, 2, 0); set_sync(4'h0, 1, 0);
    run_cmd("mix_noresp", 1'b0, 1'b0, 16'h8001, 8'h00, 8'hE4, -1);

    // Reset during ADDR
    set_sync(4'h0, 1, 1);
    run_cmd("rst_mid", 1'b1, 1'b0, 16'hBEEF, 8'h42, 8'h00, 4);
    lpc_lreset_n = 1'b0;
    lpc_lad_i = 4'hF;
    #1 chk("rst_mid.bus", 32'({lpc_lframe_n, lpc_lad_oe, rsp_valid, cmd_ready}),
           32'({1'b1, 1'b0, 1'b0, 1'b0}));
    repeat (2) begin
      @(negedge lpc_lclk);
      chk("rst_mid.norsp", 32'(rsp_valid), 32'(0));
    end
    lpc_lreset_n = 1'b1;
    #1 chk("rst_mid.ready0", 32'(cmd_ready), 32'(0));
    @(negedge lpc_lclk);
    chk("rst_mid.ready1", 32'(cmd_ready), 32'(1));
    set_sync(4'h0, 1, 1);
    run_cmd("after_rst", 1'b0, 1'b0, 16'h0070, 8'h00, 8'hA9, -1);
    @(negedge lpc_lclk);
    chk("idle", 32'({rsp_valid, cmd_ready, lpc_lframe_n, lpc_lad_oe}),
        32'({1'b0, 1'b1, 1'b1, 1'b0}));

    // Randomized commands, mostly back-to-back
    for (int t = 0; t < 40; t++) begin
      sync_q.delete();
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin
          len = $urandom_range(0, 4);
          repeat (len) sync_q.push_back(($urandom % 2) ? 4'h5 : 4'h6);
          sync_q.push_back(($urandom % 4 == 0) ? 4'hA : 4'h0);
        end
        1: begin
          set_sync(4'h5, $urandom_range(7, 10), 0);
          sync_q.push_back(4'h0);
        end
        2: begin
          len = $urandom_range(0, 5);
          repeat (len) sync_q.push_back(code_pool[$urandom % 6]);
        end
        default: sync_q.push_back(4'h0);
      endcase
      wr = 1'($urandom);
      run_cmd($sformatf("rnd%0d", t), wr, 1'($urandom), 16'($urandom), 8'($urandom),
              8'($urandom), -1);
      if ($urandom % 3 == 0) repeat ($urandom_range(1, 3)) @(negedge lpc_lclk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
